// File: rtl/aurora_axi_rx_demux_pkg.sv
// Shared definitions for the Aurora AXI-Stream RX demux and its TX-mux counterpart.
// Holds the stream beat format and the frame-routing state encoding.
package aurora_axi_rx_demux_pkg;

    localparam int AXIS_DW = 32;
    localparam int AXIS_KW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic               last;
        logic [AXIS_KW-1:0] keep;
        logic [AXIS_DW-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/aurora_axi_rx_demux_reg_slice.sv
// One-deep AXI-Stream register slice (data + keep + last) feeding one MAC TX buffer.
// The upstream side is a plain load strobe; the parent only loads when the slot is free.
module axis_reg_slice
    import aurora_axi_rx_demux_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  axis_beat_t beat_in,
    input  logic       m_tready,
    output logic       m_tvalid,
    output axis_beat_t m_beat
);

    logic       valid_q, valid_d;
    axis_beat_t beat_q, beat_d;

    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (load) begin
            valid_d = 1'b1;
            beat_d  = beat_in;
        end else if (valid_q && m_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign m_tvalid = valid_q;
    assign m_beat   = beat_q;

endmodule

// File: rtl/aurora_axi_rx_demux.sv
// Routes whole frames from the Aurora RX user stream to one of ETHCOUNT per-port streams;
// frames aimed at masked or out-of-range ports are drained and counted.
//
//   state | meaning
//   IDLE  | waiting for a first beat; routing decided from sel/eth_mask on that beat
//   PASS  | mid-frame, forwarding every beat to the latched port
//   DROP  | mid-frame, discarding beats until tlast
module aurora_axi_rx_demux
    import aurora_axi_rx_demux_pkg::*;
#(
    parameter int ETHCOUNT  = 4,
    parameter int SIM       = 0,
    parameter int DROPCNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [$clog2(ETHCOUNT)-1:0]   sel,
    input  logic [ETHCOUNT-1:0]           eth_mask,
    output logic                          axis_s_tready,
    input  logic [AXIS_DW-1:0]            axis_s_tdata,
    input  logic [AXIS_KW-1:0]            axis_s_tkeep,
    input  logic                          axis_s_tvalid,
    input  logic                          axis_s_tlast,
    input  logic [ETHCOUNT-1:0]           axis_m_tready,
    output logic [ETHCOUNT*AXIS_DW-1:0]   axis_m_tdata,
    output logic [ETHCOUNT*AXIS_KW-1:0]   axis_m_tkeep,
    output logic [ETHCOUNT-1:0]           axis_m_tvalid,
    output logic [ETHCOUNT-1:0]           axis_m_tlast,
    output logic [DROPCNT_W-1:0]          drop_cnt,
    output logic                          busy
);

    localparam int SEL_W = $clog2(ETHCOUNT);

    if (SIM != 0) begin : g_sim_build
    end

    rx_state_e            state_q, state_d;
    logic [SEL_W-1:0]     dst_q, dst_d;
    logic [DROPCNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                 rdy_en_q, rdy_en_d;

    logic [ETHCOUNT-1:0]  sel_oh, dst_oh, eff_oh, slot_free, load_vec, m_tvalid_w;
    logic                 port_ok, ready_fwd, fwd, s_tready_w, accept;
    axis_beat_t           beat_in;
    axis_beat_t           beat_out [ETHCOUNT];

    // sel values at or above ETHCOUNT decode to no port, which makes port_ok false.
    always_comb begin
        sel_oh = '0;
        dst_oh = '0;
        for (int n = 0; n < ETHCOUNT; n++) begin
            if (sel == SEL_W'(n))   sel_oh[n] = 1'b1;
            if (dst_q == SEL_W'(n)) dst_oh[n] = 1'b1;
        end
    end

    assign slot_free = ~m_tvalid_w | axis_m_tready;
    assign eff_oh    = (state_q == ST_IDLE) ? sel_oh : dst_oh;
    assign port_ok   = |(sel_oh & ~eth_mask);
    assign ready_fwd = |(eff_oh & slot_free);
    assign rdy_en_d  = 1'b1;

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        drop_cnt_d = drop_cnt_q;
        fwd        = 1'b0;
        s_tready_w = 1'b0;

        case (state_q)
            ST_IDLE: begin
                fwd        = port_ok;
                s_tready_w = port_ok ? ready_fwd : 1'b1;
            end
            ST_PASS: begin
                fwd        = 1'b1;
                s_tready_w = ready_fwd;
            end
            ST_DROP: s_tready_w = 1'b1;
            default: state_d = ST_IDLE;
        endcase

        // Held low from reset until the first clock after release.
        s_tready_w = s_tready_w & rdy_en_q;
        accept     = axis_s_tvalid & s_tready_w;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    dst_d = sel;
                    if (!axis_s_tlast) state_d = port_ok ? ST_PASS : ST_DROP;
                end
                ST_PASS, ST_DROP: begin
                    if (axis_s_tlast) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (!fwd && axis_s_tlast && (drop_cnt_q != '1))
                drop_cnt_d = drop_cnt_q + DROPCNT_W'(1);
        end

        load_vec = (accept && fwd) ? eff_oh : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            dst_q      <= '0;
            drop_cnt_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            drop_cnt_q <= drop_cnt_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    assign beat_in = '{last: axis_s_tlast, keep: axis_s_tkeep, data: axis_s_tdata};

    for (genvar n = 0; n < ETHCOUNT; n++) begin : g_port
        axis_reg_slice u_slice (
            .clk      (clk),
            .rstn     (rstn),
            .load     (load_vec[n]),
            .beat_in  (beat_in),
            .m_tready (axis_m_tready[n]),
            .m_tvalid (m_tvalid_w[n]),
            .m_beat   (beat_out[n])
        );
        assign axis_m_tdata[n*AXIS_DW +: AXIS_DW] = beat_out[n].data;
        assign axis_m_tkeep[n*AXIS_KW +: AXIS_KW] = beat_out[n].keep;
        assign axis_m_tlast[n]                    = beat_out[n].last;
    end

    assign axis_m_tvalid = m_tvalid_w;
    assign axis_s_tready = s_tready_w;
    assign drop_cnt      = drop_cnt_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aurora_axi_rx_demux.sv
// Scoreboard bench for aurora_axi_rx_demux: a frame-level model queues expected beats
// per port and a negedge monitor pops and compares whatever each port hands over.
module tb_aurora_axi_rx_demux;

    localparam int EC       = 4;
    localparam int SW       = 2;
    localparam int DW       = 2;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic               clk = 1'b0;
    logic               rstn;
    logic [SW-1:0]      sel;
    logic [EC-1:0]      eth_mask;
    logic               s_tready;
    logic [31:0]        s_tdata;
    logic [3:0]         s_tkeep;
    logic               s_tvalid;
    logic               s_tlast;
    logic [EC-1:0]      m_tready;
    logic [EC*32-1:0]   m_tdata;
    logic [EC*4-1:0]    m_tkeep;
    logic [EC-1:0]      m_tvalid;
    logic [EC-1:0]      m_tlast;
    logic [DW-1:0]      drop_cnt;
    logic               busy;

    always #5 clk = ~clk;

    aurora_axi_rx_demux #(.ETHCOUNT(EC), .SIM(1), .DROPCNT_W(DW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .sel           (sel),
        .eth_mask      (eth_mask),
        .axis_s_tready (s_tready),
        .axis_s_tdata  (s_tdata),
        .axis_s_tkeep  (s_tkeep),
        .axis_s_tvalid (s_tvalid),
        .axis_s_tlast  (s_tlast),
        .axis_m_tready (m_tready),
        .axis_m_tdata  (m_tdata),
        .axis_m_tkeep  (m_tkeep),
        .axis_m_tvalid (m_tvalid),
        .axis_m_tlast  (m_tlast),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic [36:0] exp_q [EC][$];
    bit  in_frame;
    int  frame_dst;
    bit  frame_drop;
    int  drop_frames;
    int  exp_drop_next, exp_drop;
    bit  exp_busy_next, exp_busy;

    function automatic int min_sat(input int n);
        return (n > DROP_MAX) ? DROP_MAX : n;
    endfunction

    task automatic model_accept();
        if (!in_frame) begin
            frame_dst  = int'(sel);
            frame_drop = eth_mask[sel];
            in_frame   = 1'b1;
        end
        if (!frame_drop) exp_q[frame_dst].push_back({s_tlast, s_tkeep, s_tdata});
        if (s_tlast) begin
            if (frame_drop) drop_frames++;
            in_frame = 1'b0;
        end
        exp_drop_next = min_sat(drop_frames);
        exp_busy_next = in_frame;
    endtask

    task automatic model_reset();
        for (int p = 0; p < EC; p++) exp_q[p].delete();
        in_frame      = 1'b0;
        drop_frames   = 0;
        exp_drop_next = 0;
        exp_busy_next = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rstn) begin
            exp_drop = 0;
            exp_busy = 1'b0;
        end else begin
            exp_drop = exp_drop_next;
            exp_busy = exp_busy_next;
        end
    end

    // ---------------- downstream ready generator ----------------
    bit          rand_ready   = 1'b0;
    logic [EC-1:0] forced_ready = '1;

    initial forever begin
        m_tready = rand_ready ? (4'($urandom) | 4'($urandom)) : forced_ready;
        @(posedge clk);
        #1;
    end

    // ---------------- monitor ----------------
    bit          mon_en = 1'b0;
    bit          held     [EC];
    logic [36:0] held_val [EC];

    always @(negedge clk) begin
        logic [36:0] cur;
        if (!rstn) begin
            for (int p = 0; p < EC; p++) held[p] = 1'b0;
        end else if (mon_en) begin
            check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            check("busy", 64'(busy), 64'(exp_busy));
            for (int p = 0; p < EC; p++) begin
                cur = {m_tlast[p], m_tkeep[p*4 +: 4], m_tdata[p*32 +: 32]};
                if (held[p]) check($sformatf("hold_p%0d", p), {m_tvalid[p], cur}, {1'b1, held_val[p]});
                held[p] = 1'b0;
                if (m_tvalid[p]) begin
                    if (m_tready[p]) begin
                        if (exp_q[p].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat_p%0d actual=0x%0h required=none", p, cur);
                        end else begin
                            check($sformatf("beat_p%0d", p), cur, exp_q[p].pop_front());
                        end
                    end else begin
                        held[p]     = 1'b1;
                        held_val[p] = cur;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic [SW-1:0] s, input logic [EC-1:0] msk);
        bit dropping;
        @(posedge clk);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        sel      = s;
        eth_mask = msk;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            dropping = in_frame ? frame_drop : eth_mask[sel];
            if (dropping) check("drop_ready", 64'(s_tready), 64'd1);
            if (s_tready) begin
                model_accept();
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=no_ready required=ready data=0x%0h", d);
    endtask

    task automatic send_frame(input int dst, input int n, input logic [31:0] base,
                              input logic [EC-1:0] msk);
        for (int i = 0; i < n; i++)
            drive_beat(base + 32'(i), (i == n-1) ? 4'h1 : 4'hF, (i == n-1), SW'(dst), msk);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int          len, dst;
        logic [EC-1:0] cur_mask;
        bit          drained;

        rstn = 1'b0;
        sel = '0; eth_mask = '0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata", 64'(m_tdata[63:0]), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        @(posedge clk);
        #1;
        rstn = 1'b1;
        sel = 2'd2;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_s_tready", 64'(s_tready), 64'd1);
        mon_en = 1'b1;

        // basic routing to port 2
        send_frame(2, 5, 32'd1, 4'b0000);
        idle(3);

        // masked port 1 is drained, then a single beat goes to port 0
        send_frame(1, 3, 32'h100, 4'b0010);
        idle(3);
        @(negedge clk);
        check("masked_drop_cnt", 64'(drop_cnt), 64'd1);
        send_frame(0, 1, 32'h200, 4'b0010);
        idle(3);

        // sel change mid-frame is ignored
        drive_beat(32'h10, 4'hF, 1'b0, 2'd0, 4'b0000);
        drive_beat(32'h11, 4'hF, 1'b0, 2'd3, 4'b0000);
        drive_beat(32'h12, 4'hF, 1'b0, 2'd3, 4'b0000);
        drive_beat(32'h13, 4'h3, 1'b1, 2'd3, 4'b0000);
        idle(3);

        // backpressure on port 3
        fork
            send_frame(3, 8, 32'd1, 4'b0000);
            begin
                repeat (3) @(posedge clk);
                forced_ready = 4'b0111;
                repeat (2) begin
                    @(negedge clk);
                    check("bp_s_tready", 64'(s_tready), 64'd0);
                    check("bp_tvalid3", 64'(m_tvalid[3]), 64'd1);
                end
                repeat (2) @(posedge clk);
                forced_ready = 4'b1111;
            end
        join
        idle(4);

        // randomized traffic
        rand_ready = 1'b1;
        cur_mask   = '0;
        for (int f = 0; f < 150; f++) begin
            dst = $urandom_range(0, EC-1);
            len = $urandom_range(1, 6);
            cur_mask = ($urandom_range(0, 3) == 0) ? EC'($urandom) : '0;
            for (int i = 0; i < len; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) cur_mask = EC'($urandom);
                drive_beat($urandom, (i == len-1) ? 4'($urandom_range(1, 15)) : 4'hF,
                           (i == len-1), (i == 0) ? SW'(dst) : SW'($urandom), cur_mask);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
        end
        rand_ready   = 1'b0;
        forced_ready = '1;
        idle(6);

        // asynchronous reset with a beat parked in port 1
        forced_ready = 4'b1101;
        idle(2);
        drive_beat(32'hA5, 4'hF, 1'b0, 2'd1, 4'b0000);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_tvalid1", 64'(m_tvalid[1]), 64'd1);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("async_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("async_rst_s_tready", 64'(s_tready), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        forced_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        send_frame(2, 1, 32'h77, 4'b0000);
        idle(3);

        // dropped-frame counter saturation
        for (int i = 0; i < 5; i++) send_frame(3, 1, 32'h300 + 32'(i), 4'b1000);
        idle(3);
        @(negedge clk);
        check("drop_sat", 64'(drop_cnt), 64'(DROP_MAX));

        drained = 1'b0;
        for (int t = 0; t < 100 && !drained; t++) begin
            @(negedge clk);
            drained = 1'b1;
            for (int p = 0; p < EC; p++) if (exp_q[p].size() != 0) drained = 1'b0;
        end
        for (int p = 0; p < EC; p++) check($sformatf("drain_p%0d", p), 64'(exp_q[p].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_axi_rx_demux.md
Name: aurora_axi_rx_demux

Overview:
- Receive-side counterpart of the Aurora TX mux.
- Takes the single 32-bit AXI-Stream from the Aurora RX user interface and routes each whole frame to one of ETHCOUNT per-Ethernet AXI-Stream outputs.
- Each output feeds a MAC TX buffer.
- Frames for masked or out-of-range ports are drained and counted, never forwarded.

Parameters:
ETHCOUNT, 4, number of Ethernet output ports (2..8)
SIM, 0, simulation build flag; no functional effect in this block
DROPCNT_W, 16, width of the saturating dropped-frame counter

Ports:
clk  input  1  system clock
rstn  input  1  reset; asynchronous, active-low
sel  input  $clog2(ETHCOUNT)  destination port for the next frame; sampled on a frame's first beat only
eth_mask  input  ETHCOUNT  bit n = 1 disables port n; frames routed there are dropped
axis_s_tready  output  1  upstream ready
axis_s_tdata  input  32  upstream data
axis_s_tkeep  input  4  upstream byte enables
axis_s_tvalid  input  1  upstream valid
axis_s_tlast  input  1  upstream end of frame
axis_m_tready  input  ETHCOUNT  per-port ready
axis_m_tdata  output  ETHCOUNT*32  per-port data, port n at [n*32+31:n*32]
axis_m_tkeep  output  ETHCOUNT*4  per-port byte enables
axis_m_tvalid  output  ETHCOUNT  per-port valid
axis_m_tlast  output  ETHCOUNT  per-port end of frame
drop_cnt  output  DROPCNT_W  dropped-frame count
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE, dst=0.
  - All axis_m_tvalid=0. axis_m_tdata, axis_m_tkeep and axis_m_tlast = 0.
  - drop_cnt=0, busy=0.
  - axis_s_tready=0 while rstn is low.
- Beat accept: accepted when axis_s_tvalid & axis_s_tready at a clk rising edge.
- State IDLE: a beat is treated as the first beat of a frame.
  - eff_dst = sel (combinational, used for this beat). dst <= sel.
  - If sel >= ETHCOUNT or eth_mask[sel]=1: the beat is discarded. If the beat has tlast=0, go to DROP.
  - Otherwise the beat is forwarded. If the beat has tlast=0, go to PASS.
  - If tlast=1, stay in IDLE: single-beat frame, forwarded or dropped by the same rule.
- State PASS: every beat goes to port dst. On an accepted tlast beat, return to IDLE.
- State DROP: axis_s_tready=1 constantly. Beats are discarded. On an accepted tlast beat, return to IDLE.
- Frame-level gating: sel and eth_mask changes after the first beat are ignored until the frame ends.
- Dropped-frame count: drop_cnt increments by 1 on each dropped frame's tlast beat, including single-beat frames. It saturates at all-ones.
- Output stage: one register slice per port, so forward latency is 1 cycle (accept at edge k, axis_m_tvalid[dst] high after edge k).
- Ready when forwarding: axis_s_tready = ~axis_m_tvalid[eff_dst] | axis_m_tready[eff_dst]. This sustains full throughput without a skid buffer.
- Port slice update:
  - Loads tdata, tkeep and tlast when a beat for that port is accepted.
  - Clears tvalid when the port's handshake completes and no new beat is loaded.
  - Holds all values while tvalid=1 & tready=0 (AXIS stability).
- Non-selected ports: they keep draining independently. The previous frame's last beat may still sit in port A's slice while a new frame starts toward port B.
- tkeep: passed through unmodified. No width conversion and no byte reordering.
- Reset mid-frame: the partial frame is abandoned, including output slice contents. The next accepted beat after reset release is treated as a first beat.

Decomposition:
- Shared package: state encoding IDLE/PASS/DROP and constants AXIS_DW=32, AXIS_KW=4. These are also usable by the TX mux.
- One natural sub-module, axis_reg_slice: 32-bit data + keep + last, 1-deep, valid/ready. Instantiated ETHCOUNT times by a generate loop.

Test Plan:
- Reset: rstn low -> all axis_m_tvalid=0, drop_cnt=0, axis_s_tready=0; rstn high, sel=2, eth_mask=0 -> axis_s_tready=1 next cycle.
- Basic routing: sel=2, 5-beat frame, data 1..5, tkeep=4'hF, last beat tkeep=4'h1, all ready=1 -> port 2 emits 1..5 one cycle delayed; tlast on data 5; ports 0,1,3 stay tvalid=0.
- Masked port: eth_mask=4'b0010, sel=1, 3-beat frame -> no output tvalid, axis_s_tready=1 throughout, drop_cnt=1. Next, sel=0, 1-beat frame -> forwarded on port 0.
- Mid-frame sel change: sel=0 at first beat, sel=3 on beat 2 of 4 -> all 4 beats on port 0.
- Backpressure: axis_m_tready[3]=0 for 4 cycles during a frame to port 3 -> axis_s_tready=0 while slice full; port 3 data held stable; no beat lost or duplicated; sequence 1..8 intact.
- Counter saturation (DROPCNT_W=2): 5 dropped 1-beat frames -> drop_cnt=3. Async reset asserted mid-frame to port 1 -> port 1 tvalid drops immediately; next frame routed fresh by sel.
